// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider -- multi-cycle restoring divider (one quotient bit per cycle).
//
// Configuration macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : signed_op selects a two's-complement divide (truncating
//               toward zero, remainder carries the dividend's sign).
//   undefined : signed_op is ignored, every divide is unsigned and no sign
//               logic is built. Latency is the same in both builds.
//
// Ports
//   clock        rising-edge clock for all state
//   clear        synchronous active-high reset (wins over start)
//   start        divide request, only looked at while busy is low
//   signed_op    1 = signed divide, 0 = unsigned divide
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   quotient     LO result, updated on entry to DONE
//   remainder    HI result, updated on entry to DONE
//   busy         high from the accepting edge until done drops
//   done         one-cycle pulse while the results become valid
//   div_by_zero  divisor was zero for the last completed divide (held)
//
// Done is high in the cycle after the (WIDTH+2)th edge following acceptance;
// a new divide can be accepted every WIDTH+4 cycles.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_raw_r, dvs_raw_r;
  logic [WIDTH-1:0] q_r, rem_r, dvs_mag_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             busy_r, done_r, dbz_r;

  logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
  logic [WIDTH:0]   rem_shift_s, sub_s;
  logic             ge_s, dvs_zero_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sop_r, neg_q_r, neg_r_r;
  logic neg_dvd_s, neg_dvs_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand signs only matter for a signed divide.
  assign neg_dvd_s = sop_r & dvd_raw_r[WIDTH-1];
  assign neg_dvs_s = sop_r & dvs_raw_r[WIDTH-1];
  assign dvd_mag_s = neg_dvd_s ? negate(dvd_raw_r) : dvd_raw_r;
  assign dvs_mag_s = neg_dvs_s ? negate(dvs_raw_r) : dvs_raw_r;

  // Sign bookkeeping: operation mode at accept, result signs in PREP.
  always_ff @(posedge clock) begin
    if (clear) begin
      sop_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sop_r <= signed_op;
          end
        end
        PREP: begin
          neg_q_r <= neg_dvd_s ^ neg_dvs_s;
          neg_r_r <= neg_dvd_s;
        end
        default: begin
        end
      endcase
    end
  end
`else
  logic signed_op_unused_s;
  assign signed_op_unused_s = signed_op;
  assign dvd_mag_s = dvd_raw_r;
  assign dvs_mag_s = dvs_raw_r;
`endif

  // Restoring step: the borrow out of the WIDTH+1-bit subtract decides the bit.
  assign rem_shift_s = {1'b0, rem_r, q_r[WIDTH-1]};
  assign sub_s       = rem_shift_s - {1'b0, dvs_mag_r};
  assign ge_s        = ~sub_s[WIDTH];
  assign dvs_zero_s  = (dvs_raw_r == {WIDTH{1'b0}});

  // Final result correction applied while in FIX.
  always_comb begin
    q_fix_s = q_r;
    r_fix_s = rem_r;
    if (dvs_zero_s) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = dvd_raw_r;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (neg_q_r) begin
        q_fix_s = negate(q_r);
      end else begin
        q_fix_s = q_r;
      end
      if (neg_r_r) begin
        r_fix_s = negate(rem_r);
      end else begin
        r_fix_s = rem_r;
      end
`else
      q_fix_s = q_r;
      r_fix_s = rem_r;
`endif
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = PREP;
        end else begin
          state_s = IDLE;
        end
      end
      PREP: state_s = ITER;
      ITER: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = ITER;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (clear) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

  // Datapath: capture, prepare, iterate, publish results.
  always_ff @(posedge clock) begin
    if (clear) begin
      dvd_raw_r   <= {WIDTH{1'b0}};
      dvs_raw_r   <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dvs_mag_r   <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_raw_r <= dividend;
            dvs_raw_r <= divisor;
          end
        end
        PREP: begin
          q_r       <= dvd_mag_s;
          dvs_mag_r <= dvs_mag_s;
          rem_r     <= {WIDTH{1'b0}};
          cnt_r     <= CW'(WIDTH - 1);
        end
        ITER: begin
          rem_r <= ge_s ? sub_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], ge_s};
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          dbz_r       <= dvs_zero_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 32-bit and an 8-bit instance,
// scoreboard queues filled by the driver, monitors comparing on done.
module tb_seq_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;

  logic        start32 = 1'b0, sop32 = 1'b0;
  logic [31:0] dividend32 = 32'd0, divisor32 = 32'd0;
  logic [31:0] quotient32, remainder32;
  logic        busy32, done32, dbz32;

  logic        start8 = 1'b0, sop8 = 1'b0;
  logic [7:0]  dividend8 = 8'd0, divisor8 = 8'd0;
  logic [7:0]  quotient8, remainder8;
  logic        busy8, done8, dbz8;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  seq_divider #(.WIDTH(32)) u_div32 (
    .clock(clock), .clear(clear), .start(start32), .signed_op(sop32),
    .dividend(dividend32), .divisor(divisor32),
    .quotient(quotient32), .remainder(remainder32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  seq_divider #(.WIDTH(8)) u_div8 (
    .clock(clock), .clear(clear), .start(start8), .signed_op(sop8),
    .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division on w-bit operands.
  function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic z);
    logic [63:0] mask, a, b;
    longint      sa, sb;
    logic        use_signed;
    use_signed = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    use_signed = s;
`else
    use_signed = s & 1'b0;
`endif
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    q = 64'd0; r = 64'd0; z = 1'b0;
    if (b == 64'd0) begin
      q = mask; r = a; z = 1'b1;
    end else if (use_signed) begin
      sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Wait for the chosen instance to be idle, issue one divide, log expectation.
  task automatic op(input bit w8, input logic [63:0] a, input logic [63:0] b, input logic s);
    int          t;
    exp_t        e;
    logic [63:0] q, r;
    logic        z;
    t = 0;
    @(negedge clock);
    while ((w8 ? busy8 : busy32) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (w8 ? busy8 : busy32) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0");
      return;
    end
    if (w8) begin
      dividend8 = a[7:0]; divisor8 = b[7:0]; start8 = 1'b1;
    end else begin
      dividend32 = a[31:0]; divisor32 = b[31:0]; sop32 = s; start32 = 1'b1;
    end
    @(posedge clock);
    #1;
    model(w8 ? 8 : 32, a, b, w8 ? 1'b0 : s, q, r, z);
    e.q = q; e.r = r; e.z = z; e.acc = cyc;
    if (w8) begin
      sb8.push_back(e); start8 = 1'b0;
    end else begin
      sb32.push_back(e); start32 = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (sb32.size() != 0 || sb8.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", sb32.size(), sb8.size());
      sb32.delete();
      sb8.delete();
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clock) begin
    exp_t e;
    if (done32) begin
      if (sb32.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done32: got done=1 expected no done");
      end else begin
        e = sb32.pop_front();
        chk("quotient32", {32'd0, quotient32}, e.q);
        chk("remainder32", {32'd0, remainder32}, e.r);
        chk("dbz32", {63'd0, dbz32}, {63'd0, e.z});
        chk("latency32", 64'(cyc - e.acc), 64'd34);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clock) begin
    exp_t e;
    if (done8) begin
      if (sb8.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done8: got done=1 expected no done");
      end else begin
        e = sb8.pop_front();
        chk("quotient8", {56'd0, quotient8}, e.q);
        chk("remainder8", {56'd0, remainder8}, e.r);
        chk("dbz8", {63'd0, dbz8}, {63'd0, e.z});
        chk("latency8", 64'(cyc - e.acc), 64'd10);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a, b;
    int          k;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_q32", {32'd0, quotient32}, 64'd0);
    chk("reset_r32", {32'd0, remainder32}, 64'd0);
    chk("reset_busy_done32", {62'd0, busy32, done32}, 64'd0);
    chk("reset_dbz32", {63'd0, dbz32}, 64'd0);
    chk("reset_busy8", {63'd0, busy8}, 64'd0);
    clear = 1'b0;

    // Directed cases.
    op(1'b0, 64'h54, 64'h6, 1'b0);
    op(1'b0, 64'd100, 64'd7, 1'b0);
    op(1'b0, 64'hFFFFFFF9, 64'd2, 1'b1);
    op(1'b0, 64'd5, 64'd0, 1'b0);
    op(1'b0, 64'd9, 64'd3, 1'b0);
    op(1'b0, 64'h80000000, 64'hFFFFFFFF, 1'b1);
    op(1'b0, 64'h80000000, 64'hFFFFFFFF, 1'b0);
    op(1'b0, 64'hFFFFFFF9, 64'd0, 1'b1);
    op(1'b1, 64'd200, 64'd9, 1'b0);
    op(1'b1, 64'd7, 64'd0, 1'b0);

    // Randomized cases, both instances interleaved.
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 7);
      a = {32'd0, $urandom};
      if (k == 0) b = 64'd0;
      else if (k < 4) b = 64'($urandom_range(1, 300));
      else b = {32'd0, $urandom};
      op(1'b0, a, b, 1'($urandom_range(0, 1)));
      if (i % 3 == 0) op(1'b1, {56'd0, 8'($urandom)}, {56'd0, 8'($urandom_range(0, 255))}, 1'b0);
    end
    drain();

    // Inputs wiggled and start re-asserted while busy: must not matter.
    op(1'b0, 64'd1000, 64'd7, 1'b0);
    repeat (8) begin
      @(negedge clock);
      start32 = 1'b1; dividend32 = $urandom; divisor32 = $urandom;
      sop32 = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    start32 = 1'b0;
    drain();

    // Abort with clear mid-divide, then restart on the very next edge.
    op(1'b0, 64'hFFFF0000, 64'd3, 1'b0);
    repeat (10) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    sb32.delete();
    chk("clear_q32", {32'd0, quotient32}, 64'd0);
    chk("clear_r32", {32'd0, remainder32}, 64'd0);
    chk("clear_busy_done_dbz32", {61'd0, busy32, done32, dbz32}, 64'd0);
    clear = 1'b0;
    dividend32 = 32'd84; divisor32 = 32'd6; sop32 = 1'b0; start32 = 1'b1;
    @(posedge clock);
    #1;
    begin
      exp_t e;
      e.q = 64'd14; e.r = 64'd0; e.z = 1'b0; e.acc = cyc;
      sb32.push_back(e);
    end
    start32 = 1'b0;
    @(negedge clock);
    chk("restart_busy32", {63'd0, busy32}, 64'd1);
    drain();

    // Quiet period: any queued or spurious done is caught by the monitors.
    repeat (60) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
